prog_mealy_fsm: RTL
===================

// Module: prog_mealy_fsm
// PURPOSE
//   Table-driven Mealy FSM that replaces hand-coded casex controllers.
//   A transition table of NROWS rows is loaded over a config port while
//   the machine is idle. Each row is {state, care mask, match value,
//   next state, output}. Sits between the input sampler and the output
//   driver in place of fixed 7-in/7-out controllers, with optional
//   registered outputs and explicit no-match reporting.
// PARAMETERS
//   IN_W        7      input vector width
//   OUT_W       7      output vector width
//   NSTATE      36     number of legal states; ST_W = clog2(NSTATE)
//   NROWS       128    transition-table rows; ROW_W = clog2(NROWS)
//   RESET_STATE 0      state entered on rst
//   DEFAULT_OUT 0      output when idle or when no row matches
//   OUT_REG     0      0: combinational Mealy out; 1: out registered (+1 cycle)
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous active-high reset
//   run        in   1      1: FSM advances each cycle; 0: hold state, table writable
//   in         in   IN_W   FSM input vector
//   out        out  OUT_W  FSM output vector
//   state      out  ST_W   present state
//   hit        out  1      a row matched this cycle (0 when run=0)
//   hit_row    out  ROW_W  index of matching row (0 when hit=0)
//   nomatch    out  1      run=1 and no row matched this cycle
//   cfg_we     in   1      table write strobe
//   cfg_addr   in   ROW_W  row index
//   cfg_valid  in   1      row valid bit to write
//   cfg_state  in   ST_W   row present-state field
//   cfg_mask   in   IN_W   care mask (1 = bit compared)
//   cfg_match  in   IN_W   match value
//   cfg_next   in   ST_W   row next-state field
//   cfg_out    in   OUT_W  row output field
//   cfg_err    out  1      sticky: rejected config write
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state<=RESET_STATE, all row valid bits<=0,
//     cfg_err<=0, registered out<=DEFAULT_OUT. Other row fields are not reset.
//     rst takes priority over cfg_we and run in the same cycle.
//   - Row r matches iff valid[r] && st[r]==state && ((in^match[r])&mask[r])==0.
//     mask=0 matches any input for that state.
//   - Priority: lowest matching row index wins. Overlapping rows are legal.
//   - run=1 and match: next state <= next[r]; out = out[r]; hit=1;
//     hit_row=r; nomatch=0.
//   - run=1 and no match: state holds; out=DEFAULT_OUT; hit=0; nomatch=1.
//   - run=0: state holds; out=DEFAULT_OUT; hit=0; nomatch=0.
//   - OUT_REG=0: out, hit, hit_row, nomatch combinational from state and in
//     in the same cycle. OUT_REG=1: out registered, valid the cycle after
//     the transition; hit/hit_row/nomatch stay combinational.
//   - Config writes are accepted only when run=0, cfg_addr<NROWS,
//     cfg_state<NSTATE and cfg_next<NSTATE. An accepted write updates the
//     row at the posedge and is visible the next cycle.
//   - Config write with run=1 or any field out of range: write ignored,
//     cfg_err<=1 (sticky until rst).
//   - run may toggle on any cycle. A write in the same cycle as run falling
//     is evaluated against run=0 (current-cycle value).
//   - Illegal state is unreachable: next fields are range-checked on write.
// TESTING
//   - rst; load r0{st0,mask40,match00,nx0,out00}, r1{st0,mask60,match40,
//     nx1,out18}; run=1, in=7'h40 -> out=7'h18, hit_row=1, state=1 next cycle.
//   - Priority: r2,r3 both st1 mask00, nx2/nx3 -> hit_row=2, state=2.
//   - No match: state 2 with no rows -> nomatch=1, out=DEFAULT_OUT, state
//     stays 2 for 5 cycles.
//   - cfg_we with run=1, and cfg_next=NSTATE with run=0 -> both writes
//     ignored (table readback via behaviour unchanged), cfg_err=1 until rst.
//   - OUT_REG=1 repeat of test 1 -> out=7'h18 one cycle later than OUT_REG=0.
//   - rst asserted mid-run in state 3 together with cfg_we -> state=0,
//     all rows invalid (nomatch=1 when run=1), write discarded.

Source files
------------

// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm
//   Table-driven Mealy state machine. A transition table of NROWS rows is
//   loaded through the cfg_* port while the machine is idle (run_i=0). Each
//   row holds {valid, present state, care mask, match value, next state,
//   output}. While running, the lowest-indexed valid row whose state equals
//   the present state and whose masked match value equals the masked input
//   fires: the state advances to the row's next state and the row's output
//   is driven. Without a matching row the state holds and DEFAULT_OUT is
//   driven.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   run_i        1: advance each cycle; 0: hold state, table writable
//   in_i         FSM input vector
//   out_o        FSM output vector (registered when OUT_REG=1)
//   state_o      present state
//   hit_o        a row matched this cycle (0 when run_i=0)
//   hit_row_o    index of the matching row (0 when hit_o=0)
//   nomatch_o    run_i=1 and no row matched this cycle
//   cfg_we_i     table write strobe
//   cfg_addr_i   row index to write
//   cfg_valid_i  row valid bit
//   cfg_state_i  row present-state field
//   cfg_mask_i   row care mask (1 = bit compared)
//   cfg_match_i  row match value
//   cfg_next_i   row next-state field
//   cfg_out_i    row output field
//   cfg_err_o    sticky flag: a config write was rejected
module prog_mealy_fsm #(
  parameter int IN_W        = 7,
  parameter int OUT_W       = 7,
  parameter int NSTATE      = 36,
  parameter int NROWS       = 128,
  parameter int RESET_STATE = 0,
  parameter int DEFAULT_OUT = 0,
  parameter int OUT_REG     = 0,
  localparam int ST_W       = (NSTATE > 1) ? $clog2(NSTATE) : 1,
  localparam int ROW_W      = (NROWS > 1) ? $clog2(NROWS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic [ST_W-1:0]  state_o,
  output logic             hit_o,
  output logic [ROW_W-1:0] hit_row_o,
  output logic             nomatch_o,
  input  logic             cfg_we_i,
  input  logic [ROW_W-1:0] cfg_addr_i,
  input  logic             cfg_valid_i,
  input  logic [ST_W-1:0]  cfg_state_i,
  input  logic [IN_W-1:0]  cfg_mask_i,
  input  logic [IN_W-1:0]  cfg_match_i,
  input  logic [ST_W-1:0]  cfg_next_i,
  input  logic [OUT_W-1:0] cfg_out_i,
  output logic             cfg_err_o
);

  localparam logic [ST_W-1:0]  ResetState = ST_W'(RESET_STATE);
  localparam logic [OUT_W-1:0] DefaultOut = OUT_W'(DEFAULT_OUT);

  // Transition table. Only the valid bits are reset; the other fields are
  // don't-care until their row has been written and marked valid.
  logic             rowValid_q [NROWS];
  logic [ST_W-1:0]  rowState_q [NROWS];
  logic [IN_W-1:0]  rowMask_q  [NROWS];
  logic [IN_W-1:0]  rowMatch_q [NROWS];
  logic [ST_W-1:0]  rowNext_q  [NROWS];
  logic [OUT_W-1:0] rowOut_q   [NROWS];

  logic [ST_W-1:0]  state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             cfgErr_q, cfgErr_d;

  logic             anyMatch;
  logic [ROW_W-1:0] matchRow;
  logic             hitNow;
  logic [OUT_W-1:0] combOut;
  logic             addrOk, stateOk, nextOk;
  logic             cfgAccept;

  // Config range checks are done at 32 bits so they stay meaningful even
  // when a field width exactly covers its legal range. Range-checking the
  // next-state field is what keeps illegal states unreachable.
  always_comb begin
    addrOk    = 32'(cfg_addr_i)  < 32'(NROWS);
    stateOk   = 32'(cfg_state_i) < 32'(NSTATE);
    nextOk    = 32'(cfg_next_i)  < 32'(NSTATE);
    cfgAccept = cfg_we_i && !run_i && addrOk && stateOk && nextOk;
  end

  // Row matcher: scanning from the top down lets the lowest matching row
  // index overwrite any higher one, giving lowest-index priority.
  always_comb begin
    anyMatch = 1'b0;
    matchRow = '0;
    for (int r = NROWS - 1; r >= 0; r--) begin
      if (rowValid_q[r] && (rowState_q[r] == state_q) &&
          (((in_i ^ rowMatch_q[r]) & rowMask_q[r]) == '0)) begin
        anyMatch = 1'b1;
        matchRow = ROW_W'(r);
      end
    end
  end

  // Next state, Mealy output and status flags. Everything is qualified by
  // run_i so an idle machine reports neither a hit nor a no-match.
  always_comb begin
    hitNow   = run_i && anyMatch;
    combOut  = DefaultOut;
    state_d  = state_q;
    cfgErr_d = cfgErr_q;
    if (hitNow) begin
      combOut = rowOut_q[matchRow];
      state_d = rowNext_q[matchRow];
    end
    if (cfg_we_i && !cfgAccept) begin
      cfgErr_d = 1'b1;
    end
    out_d = combOut;
  end

  // Control registers. Reset wins over both run_i and any config write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ResetState;
      out_q    <= DefaultOut;
      cfgErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      cfgErr_q <= cfgErr_d;
    end
  end

  // Valid bits are the only part of the table cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NROWS; r++) begin
        rowValid_q[r] <= 1'b0;
      end
    end else if (cfgAccept) begin
      rowValid_q[cfg_addr_i] <= cfg_valid_i;
    end
  end

  // Row payload storage, written only by accepted config writes.
  always_ff @(posedge clk_i) begin
    if (!rst_i && cfgAccept) begin
      rowState_q[cfg_addr_i] <= cfg_state_i;
      rowMask_q[cfg_addr_i]  <= cfg_mask_i;
      rowMatch_q[cfg_addr_i] <= cfg_match_i;
      rowNext_q[cfg_addr_i]  <= cfg_next_i;
      rowOut_q[cfg_addr_i]   <= cfg_out_i;
    end
  end

  assign out_o     = (OUT_REG != 0) ? out_q : combOut;
  assign state_o   = state_q;
  assign hit_o     = hitNow;
  assign hit_row_o = hitNow ? matchRow : '0;
  assign nomatch_o = run_i && !anyMatch;
  assign cfg_err_o = cfgErr_q;

endmodule
